call_stack_unit: RTL and testbench

Parametrised hardware return-address stack for the 19-bit CPU family. It replaces the fixed 16-entry inline call stack in the single-cycle top with a reusable block. The block adds configurable width and depth, a count, full/empty status, sticky overflow/underflow error flags, and a selectable overflow policy. The CPU drives `push` on CALL and `pop` on RET, and reads `top` combinationally in the same cycle as the pop.

---
 rtl/cpu19_pkg.sv | 14 +
 rtl/call_stack_unit.sv | 112 +++++++++++
 tb/tb_call_stack_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu19_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu19_pkg
// Purpose  : Shared constants for the 19-bit CPU family.
// Revision : 1.0 - initial release
// ============================================================================
package cpu19_pkg;

    localparam int WORD_W     = 19;
    localparam int OVF_REJECT = 0;
    localparam int OVF_WRAP   = 1;

endpackage : cpu19_pkg
`default_nettype wire

// File: rtl/call_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : call_stack_unit
// Purpose  : Parametrised return-address stack with count, full/empty status,
//            sticky overflow/underflow flags and selectable overflow policy.
// Revision : 1.0 - initial release
// ============================================================================
module call_stack_unit
    import cpu19_pkg::*;
#(
    parameter int DATA_W   = WORD_W,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = OVF_REJECT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       err_clr,
    output logic [DATA_W-1:0]          top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("call_stack_unit: DEPTH must be a power of two and >= 2");
        end
        if ((OVF_MODE != OVF_REJECT) && (OVF_MODE != OVF_WRAP)) begin : g_bad_mode
            $error("call_stack_unit: OVF_MODE must be 0 or 1");
        end
    endgenerate

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic               r_udf;

    logic               w_empty;
    logic               w_full;
    logic [c_PTR_W-1:0] w_top_idx;
    logic               w_replace;
    logic               w_push_only;
    logic               w_pop_only;
    logic               w_push_wr;
    logic               w_ovf_set;
    logic               w_udf_set;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL_CNT);
    // Pointer width equals log2(DEPTH), so subtraction wraps modulo DEPTH.
    assign w_top_idx = r_ptr - c_PTR_ONE;

    // A push paired with a pop on an empty stack behaves as a plain push.
    assign w_replace   = push && pop && !w_empty;
    assign w_push_only = push && !w_replace;
    assign w_pop_only  = pop && !push;
    assign w_push_wr   = w_push_only && (!w_full || (OVF_MODE == OVF_WRAP));
    assign w_ovf_set   = w_push_only && w_full;
    assign w_udf_set   = w_pop_only && w_empty;

    assign top       = w_empty ? '0 : r_mem[w_top_idx];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

    // Storage is deliberately left out of reset so it maps onto plain flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_replace) begin
                r_mem[w_top_idx] <= push_data;
            end else if (w_push_wr) begin
                r_mem[r_ptr] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_push_wr) begin
                r_ptr <= r_ptr + c_PTR_ONE;
                if (!w_full) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end else if (w_pop_only && !w_empty) begin
                r_ptr   <= r_ptr - c_PTR_ONE;
                r_count <= r_count - c_CNT_W'(1);
            end
            r_ovf <= w_ovf_set || (r_ovf && !err_clr);
            r_udf <= w_udf_set || (r_udf && !err_clr);
        end
    end

endmodule : call_stack_unit
`default_nettype wire

// File: tb/tb_call_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_stack_unit
// Purpose  : Self-checking bench: directed table, DEPTH=4 policy sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_call_stack_unit;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic [18:0] push_data;
    logic        err_clr;

    logic [18:0] top0, top1, top2;
    logic [4:0]  cnt0;
    logic [2:0]  cnt1, cnt2;
    logic        emp0, emp1, emp2;
    logic        ful0, ful1, ful2;
    logic        ovf0, ovf1, ovf2;
    logic        udf0, udf1, udf2;

    int n_vec;
    int n_err;

    call_stack_unit #(.DATA_W(19), .DEPTH(16), .OVF_MODE(0)) u_dut16 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
        .err_clr(err_clr), .top(top0), .count(cnt0), .empty(emp0), .full(ful0),
        .overflow(ovf0), .underflow(udf0)
    );

    call_stack_unit #(.DATA_W(19), .DEPTH(4), .OVF_MODE(0)) u_rej4 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
        .err_clr(err_clr), .top(top1), .count(cnt1), .empty(emp1), .full(ful1),
        .overflow(ovf1), .underflow(udf1)
    );

    call_stack_unit #(.DATA_W(19), .DEPTH(4), .OVF_MODE(1)) u_wrap4 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
        .err_clr(err_clr), .top(top2), .count(cnt2), .empty(emp2), .full(ful2),
        .overflow(ovf2), .underflow(udf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue per instance, newest entry at the back.
    logic [18:0] mq [3][$];
    int          cap  [3] = '{16, 4, 4};
    bit          wrap [3] = '{1'b0, 1'b0, 1'b1};
    bit          m_ovf[3];
    bit          m_udf[3];

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void get_dut(int k, output int t, output int c,
                                    output int e, output int f,
                                    output int o, output int u);
        case (k)
            0: begin t = top0; c = cnt0; e = emp0; f = ful0; o = ovf0; u = udf0; end
            1: begin t = top1; c = cnt1; e = emp1; f = ful1; o = ovf1; u = udf1; end
            default: begin t = top2; c = cnt2; e = emp2; f = ful2; o = ovf2; u = udf2; end
        endcase
    endfunction

    function automatic void model_update(int k);
        int  sz;
        bit  ovs, uds;
        sz  = mq[k].size();
        ovs = 1'b0;
        uds = 1'b0;
        if (!rst) begin
            mq[k].delete();
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
        end else begin
            if (push && pop && sz > 0) begin
                mq[k][sz-1] = push_data;
            end else if (push) begin
                if (sz < cap[k]) begin
                    mq[k].push_back(push_data);
                end else begin
                    ovs = 1'b1;
                    if (wrap[k]) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(push_data);
                    end
                end
            end else if (pop) begin
                if (sz > 0) void'(mq[k].pop_back());
                else        uds = 1'b1;
            end
            m_ovf[k] = ovs | (m_ovf[k] & ~err_clr);
            m_udf[k] = uds | (m_udf[k] & ~err_clr);
        end
    endfunction

    function automatic void model_check(int k);
        int t, c, e, f, o, u, sz, et;
        get_dut(k, t, c, e, f, o, u);
        sz = mq[k].size();
        et = (sz == 0) ? 0 : int'(mq[k][sz-1]);
        chk($sformatf("m%0d.top", k),   t, et);
        chk($sformatf("m%0d.count", k), c, sz);
        chk($sformatf("m%0d.empty", k), e, int'(sz == 0));
        chk($sformatf("m%0d.full", k),  f, int'(sz == cap[k]));
        chk($sformatf("m%0d.ovf", k),   o, int'(m_ovf[k]));
        chk($sformatf("m%0d.udf", k),   u, int'(m_udf[k]));
    endfunction

    // One cycle: drive, clock, update the model, sample #1 after the edge.
    task automatic step(input bit r_n, input bit pu, input bit po,
                        input logic [18:0] d, input bit clr);
        rst       = r_n;
        push      = pu;
        pop       = po;
        push_data = d;
        err_clr   = clr;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_update(k);
        #1;
        for (int k = 0; k < 3; k++) model_check(k);
    endtask

    typedef struct {
        bit          rst_n;
        bit          push;
        bit          pop;
        bit          clr;
        logic [18:0] data;
        logic [18:0] e_top;
        int          e_cnt;
        bit          e_emp;
        bit          e_ovf;
        bit          e_udf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r_n, bit pu, bit po, bit clr, logic [18:0] d,
                                logic [18:0] et, int ec, bit ee, bit eo, bit eu);
        vec_t v;
        v.rst_n = r_n; v.push = pu; v.pop = po; v.clr = clr; v.data = d;
        v.e_top = et; v.e_cnt = ec; v.e_emp = ee; v.e_ovf = eo; v.e_udf = eu;
        tbl.push_back(v);
    endfunction

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        err_clr   = 1'b0;

        //   rst push pop clr data      top       cnt emp ovf udf
        add(0, 0, 0, 0, 19'h0,     19'h0,     0, 1, 0, 0);
        add(1, 1, 0, 0, 19'h00010, 19'h00010, 1, 0, 0, 0);
        add(1, 1, 0, 0, 19'h00020, 19'h00020, 2, 0, 0, 0);
        add(1, 1, 0, 0, 19'h00030, 19'h00030, 3, 0, 0, 0);
        add(1, 0, 1, 0, 19'h0,     19'h00020, 2, 0, 0, 0);
        add(1, 0, 1, 0, 19'h0,     19'h00010, 1, 0, 0, 0);
        add(1, 0, 1, 0, 19'h0,     19'h0,     0, 1, 0, 0);
        add(1, 0, 1, 0, 19'h0,     19'h0,     0, 1, 0, 1);
        add(1, 0, 1, 1, 19'h0,     19'h0,     0, 1, 0, 1);
        add(1, 0, 0, 1, 19'h0,     19'h0,     0, 1, 0, 0);
        add(1, 1, 0, 0, 19'h00011, 19'h00011, 1, 0, 0, 0);
        add(1, 1, 0, 0, 19'h00022, 19'h00022, 2, 0, 0, 0);
        add(1, 1, 1, 0, 19'h7FFFF, 19'h7FFFF, 2, 0, 0, 0);
        add(1, 0, 1, 0, 19'h0,     19'h00011, 1, 0, 0, 0);
        add(1, 0, 1, 0, 19'h0,     19'h0,     0, 1, 0, 0);
        add(1, 1, 1, 0, 19'h00005, 19'h00005, 1, 0, 0, 0);
        add(1, 1, 0, 0, 19'h00001, 19'h00001, 2, 0, 0, 0);
        add(1, 1, 0, 0, 19'h00002, 19'h00002, 3, 0, 0, 0);
        add(0, 1, 0, 0, 19'h00003, 19'h0,     0, 1, 0, 0);
        add(1, 1, 0, 0, 19'h00009, 19'h00009, 1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].push, tbl[i].pop, tbl[i].data, tbl[i].clr);
            chk($sformatf("tbl%0d.top", i),   int'(top0), int'(tbl[i].e_top));
            chk($sformatf("tbl%0d.count", i), int'(cnt0), tbl[i].e_cnt);
            chk($sformatf("tbl%0d.empty", i), int'(emp0), int'(tbl[i].e_emp));
            chk($sformatf("tbl%0d.ovf", i),   int'(ovf0), int'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d.udf", i),   int'(udf0), int'(tbl[i].e_udf));
        end

        // DEPTH=4 overflow policies: push 1..6 into both small instances.
        step(0, 0, 0, 19'h0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(1, 1, 0, 19'(i), 0);
            if (i == 5) begin
                chk("rej4.full",  int'(ful1), 1);
                chk("rej4.count", int'(cnt1), 4);
                chk("rej4.top",   int'(top1), 4);
                chk("rej4.ovf",   int'(ovf1), 1);
            end
        end
        chk("wrap4.count", int'(cnt2), 4);
        chk("wrap4.top",   int'(top2), 6);
        chk("wrap4.ovf",   int'(ovf2), 1);
        // RET reads top in the same cycle as the pop.
        for (int i = 0; i < 4; i++) begin
            rst = 1'b1; push = 1'b0; pop = 1'b1; err_clr = 1'b0;
            #1;
            chk($sformatf("rej4.pop%0d", i),  int'(top1), 4 - i);
            chk($sformatf("wrap4.pop%0d", i), int'(top2), 6 - i);
            step(1, 0, 1, 19'h0, 0);
        end
        chk("rej4.empty",  int'(emp1), 1);
        chk("wrap4.empty", int'(emp2), 1);
        chk("rej4.ovf_sticky", int'(ovf1), 1);
        step(1, 0, 0, 19'h0, 1);
        chk("rej4.ovf_clr", int'(ovf1), 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            int r;
            bit pu, po;
            r  = int'($urandom_range(0, 99));
            pu = (r < 45) || (r >= 85);
            po = (r >= 40);
            step(($urandom_range(0, 59) != 0), pu, po,
                 19'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_call_stack_unit
`default_nettype wire
